// File: rtl/mat2x2_axil_slave_if.sv
// AXI4-Lite bus bundle for the 2x2 matrix multiplier register file.
// Signal names keep the S00_AXI naming so the block drops straight behind the interconnect.
interface mat2x2_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/mat2x2_axil_slave.sv
// AXI4-Lite register file for a 2x2 unsigned 8-bit matrix multiplier; C = A x B is
// computed one element per cycle from a snapshot of A/B taken when START is written.
module mat2x2_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  mat2x2_axil_slave_if.slave  s_axi,
  output logic                done_o,
  output logic                o_dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both 1.
  // AWREADY/WREADY and ARREADY are one-cycle pulses raised only while the matching
  // VALIDs are up and no response is pending; BVALID/RVALID hold until BREADY/RREADY.
  logic                          r_wr_rdy;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

  logic [31:0] r_a, r_b;
  logic [31:0] r_sa, r_sb;
  logic [16:0] r_c [4];
  logic [0:0]  r_state;
  logic [1:0]  r_idx;
  logic        r_done;

  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic [2:0]  w_awsel, w_arsel;
  logic        w_wr_fire, w_rd_fire;
  logic        w_ctrl_wr, w_start, w_clr, w_last, w_busy;
  logic [31:0] w_rd_mux;
  logic [7:0]  w_a0, w_a1, w_b0, w_b1;
  logic [15:0] w_p0, w_p1;
  logic [16:0] w_prod;
  logic        w_unused;

  assign w_awaddr  = s_axi.S_AXI_AWADDR;
  assign w_araddr  = s_axi.S_AXI_ARADDR;
  assign w_awsel   = w_awaddr[4:2];
  assign w_arsel   = w_araddr[4:2];
  assign w_wr_fire = r_wr_rdy & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign w_rd_fire = r_arready & s_axi.S_AXI_ARVALID;
  assign w_busy    = (r_state == S_CALC);
  assign w_last    = w_busy && (r_idx == 2'd3);

  assign w_ctrl_wr = w_wr_fire && (w_awsel == 3'd2) && s_axi.S_AXI_WSTRB[0];
  assign w_start   = w_ctrl_wr && s_axi.S_AXI_WDATA[0] && (r_state == S_IDLE);
  assign w_clr     = w_ctrl_wr && s_axi.S_AXI_WDATA[1];

  // Element idx = {i, j}: cij = ai0*b0j + ai1*b1j, with aij living in byte 2i+j.
  assign w_a0   = r_idx[1] ? r_sa[23:16] : r_sa[7:0];
  assign w_a1   = r_idx[1] ? r_sa[31:24] : r_sa[15:8];
  assign w_b0   = r_idx[0] ? r_sb[15:8]  : r_sb[7:0];
  assign w_b1   = r_idx[0] ? r_sb[31:24] : r_sb[23:16];
  assign w_p0   = {8'b0, w_a0} * {8'b0, w_b0};
  assign w_p1   = {8'b0, w_a1} * {8'b0, w_b1};
  assign w_prod = {1'b0, w_p0} + {1'b0, w_p1};

  always_comb begin
    w_rd_mux = 32'b0;
    case (w_arsel)
      3'd0:    w_rd_mux = r_a;
      3'd1:    w_rd_mux = r_b;
      3'd3:    w_rd_mux = {30'b0, r_done, w_busy};
      3'd4, 3'd5, 3'd6, 3'd7:
               w_rd_mux = {15'b0, r_c[w_arsel[1:0]]};
      default: w_rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wr_rdy <= 1'b0;
      r_bvalid <= 1'b0;
      r_a      <= 32'b0;
      r_b      <= 32'b0;
    end else begin
      r_wr_rdy <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~r_bvalid & ~r_wr_rdy;
      if (w_wr_fire)
        r_bvalid <= 1'b1;
      else if (s_axi.S_AXI_BREADY)
        r_bvalid <= 1'b0;
      if (w_wr_fire && (w_awsel == 3'd0 || w_awsel == 3'd1)) begin
        for (int k = 0; k < 4; k++) begin
          if (s_axi.S_AXI_WSTRB[k]) begin
            if (w_awsel == 3'd0) r_a[8*k +: 8] <= s_axi.S_AXI_WDATA[8*k +: 8];
            else                 r_b[8*k +: 8] <= s_axi.S_AXI_WDATA[8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s_axi.S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_fire) begin
        r_rdata  <= w_rd_mux;
        r_rvalid <= 1'b1;
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_sa    <= 32'b0;
      r_sb    <= 32'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < 4; k++) r_c[k] <= 17'b0;
    end else begin
      if (w_start) begin
        r_sa    <= r_a;
        r_sb    <= r_b;
        r_idx   <= 2'd0;
        r_state <= S_CALC;
      end else if (w_busy) begin
        r_c[r_idx] <= w_prod;
        r_idx      <= r_idx + 2'd1;
        if (w_last) r_state <= S_IDLE;
      end
      // Completion beats a simultaneous CLR_DONE; START clears DONE for the new run.
      if (w_last)
        r_done <= 1'b1;
      else if (w_start || w_clr)
        r_done <= 1'b0;
    end
  end

  assign s_axi.S_AXI_AWREADY = r_wr_rdy;
  assign s_axi.S_AXI_WREADY  = r_wr_rdy;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign done_o              = r_done;
  assign o_dbg_state         = r_state;

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, w_awaddr[1:0], w_araddr[1:0]};

endmodule

// File: tb/tb_mat2x2_axil_slave.sv
// Bench for mat2x2_axil_slave: vector table, random runs against a matrix model,
// and hand-written sequences for backpressure, snapshot, priority and reset cases.
module tb_mat2x2_axil_slave;

  logic clk;
  logic rst_n;
  logic done_o;
  logic dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd, sh_a, sh_b, d32;
  logic [3:0]  s4;
  logic [1:0]  last_bresp;
  logic        last_bvalid;

  typedef struct {
    logic [31:0]       a;
    logic [31:0]       b;
    logic [3:0][31:0]  c;
  } vec_t;
  vec_t vecs [4];

  mat2x2_axil_slave_if bus ();

  mat2x2_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus),
    .done_o        (done_o),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // driver tasks: called and return 1 time unit after a rising edge
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY)) begin
      timeout_fail("write_ready");
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    last_bvalid = bus.S_AXI_BVALID;
    last_bresp  = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    data = 32'hDEAD_BEEF;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.S_AXI_ARREADY) begin
      timeout_fail("read_ready");
      bus.S_AXI_ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.S_AXI_RVALID) begin
      timeout_fail("read_rvalid");
      return;
    end
    data = bus.S_AXI_RDATA;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_o && n < 30) begin
      @(posedge clk); #1; n++;
    end
    if (!done_o) timeout_fail(name);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, 32'(bus.S_AXI_AWREADY), 32'd0);
    check({tag, "_wready"},  32'(bus.S_AXI_WREADY),  32'd0);
    check({tag, "_bvalid"},  32'(bus.S_AXI_BVALID),  32'd0);
    check({tag, "_bresp"},   32'(bus.S_AXI_BRESP),   32'd0);
    check({tag, "_arready"}, 32'(bus.S_AXI_ARREADY), 32'd0);
    check({tag, "_rvalid"},  32'(bus.S_AXI_RVALID),  32'd0);
    check({tag, "_rdata"},   bus.S_AXI_RDATA,        32'd0);
    check({tag, "_rresp"},   32'(bus.S_AXI_RRESP),   32'd0);
    check({tag, "_done_o"},  32'(done_o),            32'd0);
  endtask

  // reference model: plain 2x2 matrix product on unpacked elements
  function automatic logic [31:0] model_c(input logic [31:0] a, input logic [31:0] b,
                                          input int i, input int j);
    int am [2][2];
    int bm [2][2];
    int s;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        am[r][c] = int'(a[8*(2*r+c) +: 8]);
        bm[r][c] = int'(b[8*(2*r+c) +: 8]);
      end
    s = 0;
    for (int k = 0; k < 2; k++) s += am[i][k] * bm[k][j];
    return 32'(s);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
    return r;
  endfunction

  initial begin
    vecs[0] = '{32'h0403_0201, 32'h0807_0605, {32'h32, 32'h2B, 32'h16, 32'h13}};
    vecs[1] = '{32'h0100_0001, 32'h4433_2211, {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, {32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h1FC02, 32'h1FC02, 32'h1FC02, 32'h1FC02}};

    rst_n = 1'b0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    axi_read(5'h08, rd); check("ctrl_reads_zero", rd, 32'd0);
    axi_read(5'h1C, rd); check("c11_before_run", rd, 32'd0);
    axi_read(5'h0C, rd); check("status_after_reset", rd, 32'd0);
    axi_read(5'h00, rd); check("a_after_reset", rd, 32'd0);

    // table-driven vectors
    for (int v = 0; v < 4; v++) begin
      axi_write(5'h00, vecs[v].a, 4'hF);
      axi_write(5'h04, vecs[v].b, 4'hF);
      axi_write(5'h08, 32'h1, 4'h1);
      check("vec_done_cleared", 32'(done_o), 32'd0);
      axi_read(5'h0C, rd); check("vec_status_busy", rd, 32'h1);
      @(posedge clk); #1;
      check("vec_done_by_t5", 32'(done_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
        axi_read(5'(16 + 4*k), rd);
        check("vec_c", rd, vecs[v].c[k]);
      end
      axi_read(5'h0C, rd); check("vec_status_done", rd, 32'h2);
    end

    // CLR_DONE after the all-ones run
    axi_write(5'h08, 32'h2, 4'h1);
    axi_read(5'h0C, rd); check("clr_status", rd, 32'h0);
    check("clr_done_o", 32'(done_o), 32'd0);

    // byte strobes
    axi_write(5'h00, 32'h0, 4'hF);
    axi_write(5'h00, 32'h1234_5678, 4'b0101);
    check("strb_bresp", 32'(last_bresp), 32'd0);
    check("strb_bvalid", 32'(last_bvalid), 32'd1);
    axi_read(5'h00, rd); check("strb_a", rd, 32'h0034_0078);
    axi_read(5'h03, rd); check("addr_low_bits_ignored", rd, 32'h0034_0078);
    axi_write(5'h0C, 32'hFFFF_FFFF, 4'hF);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF);
    axi_read(5'h0C, rd); check("status_not_writable", rd, 32'h0);
    axi_read(5'h10, rd); check("c00_not_writable", rd, 32'h1FC02);

    // write response backpressure with a queued write
    bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_WDATA = 32'hA5A5_A5A5; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.S_AXI_AWREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.S_AXI_AWREADY) timeout_fail("bp_first_write");
    end
    @(posedge clk); #1;
    bus.S_AXI_WDATA = 32'h5A5A_5A5A;
    for (int c = 0; c < 10; c++) begin
      check("bp_bvalid_held", 32'(bus.S_AXI_BVALID), 32'd1);
      check("bp_no_accept", 32'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 32'd0);
      @(posedge clk); #1;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.S_AXI_AWREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.S_AXI_AWREADY) timeout_fail("bp_queued_write");
    end
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
    axi_read(5'h04, rd); check("bp_queued_data", rd, 32'h5A5A_5A5A);

    // read data backpressure with a queued read
    bus.S_AXI_ARADDR = 5'h04; bus.S_AXI_ARVALID = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.S_AXI_ARREADY) timeout_fail("rbp_ar");
    end
    @(posedge clk); #1;
    bus.S_AXI_ARADDR = 5'h00;
    axi_write(5'h04, 32'h1111_1111, 4'hF);
    for (int c = 0; c < 10; c++) begin
      check("rbp_rvalid_held", 32'(bus.S_AXI_RVALID), 32'd1);
      check("rbp_rdata_stable", bus.S_AXI_RDATA, 32'h5A5A_5A5A);
      check("rbp_no_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
      @(posedge clk); #1;
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin @(posedge clk); #1; n++; end
      if (!bus.S_AXI_ARREADY) timeout_fail("rbp_queued_ar");
    end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    check("rbp_queued_data", bus.S_AXI_RDATA, 32'h0034_0078);
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;

    // random operands and strobes against the matrix model (scoreboard)
    sh_a = 32'h0034_0078;
    sh_b = 32'h1111_1111;
    for (int it = 0; it < 16; it++) begin
      d32 = $urandom;
      s4  = 4'($urandom_range(0, 15));
      axi_write(5'h00, d32, s4);
      sh_a = merge(sh_a, d32, s4);
      d32 = $urandom;
      axi_write(5'h04, d32, 4'hF);
      sh_b = d32;
      axi_write(5'h08, 32'h1, 4'h1);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) exp_q.push_back(model_c(sh_a, sh_b, i, j));
      wait_done("rand_done");
      axi_read(5'h00, rd); check("rand_a", rd, sh_a);
      for (int k = 0; k < 4; k++) begin
        axi_read(5'(16 + 4*k), rd);
        check("rand_c", rd, exp_q.pop_front());
      end
    end

    // second START while busy is ignored
    axi_write(5'h00, 32'h0403_0201, 4'hF);
    axi_write(5'h04, 32'h0807_0605, 4'hF);
    axi_write(5'h08, 32'h1, 4'h1);
    axi_write(5'h08, 32'h1, 4'h1);
    axi_read(5'h0C, rd); check("restart_ignored_status", rd, 32'h2);
    axi_read(5'h1C, rd); check("restart_ignored_c11", rd, 32'h32);

    // A rewritten mid-run: results use the snapshot
    axi_write(5'h08, 32'h1, 4'h1);
    axi_write(5'h00, 32'h0, 4'hF);
    wait_done("snap_done");
    axi_read(5'h10, rd); check("snap_c00", rd, 32'h13);
    axi_read(5'h14, rd); check("snap_c01", rd, 32'h16);
    axi_read(5'h18, rd); check("snap_c10", rd, 32'h2B);
    axi_read(5'h1C, rd); check("snap_c11", rd, 32'h32);
    axi_read(5'h00, rd); check("snap_a_updated", rd, 32'h0);

    // START + CLR_DONE together: START wins
    axi_write(5'h00, 32'h0403_0201, 4'hF);
    axi_write(5'h08, 32'h3, 4'h1);
    check("start_clr_done_o", 32'(done_o), 32'd0);
    axi_read(5'h0C, rd); check("start_clr_status", rd, 32'h1);
    wait_done("start_clr_done");

    // CLR_DONE landing on the completion edge: DONE stays set
    axi_write(5'h08, 32'h1, 4'h1);
    @(posedge clk); #1;
    axi_write(5'h08, 32'h2, 4'h1);
    check("clr_vs_complete_done_o", 32'(done_o), 32'd1);
    axi_read(5'h0C, rd); check("clr_vs_complete_status", rd, 32'h2);

    // asynchronous reset in the middle of a run
    axi_read(5'h1C, rd); check("pre_reset_c11", rd, 32'h32);
    axi_write(5'h08, 32'h1, 4'h1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_outputs_zero("midcalc_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(5'h0C, rd); check("post_reset_status", rd, 32'h0);
    axi_read(5'h00, rd); check("post_reset_a", rd, 32'h0);
    axi_read(5'h04, rd); check("post_reset_b", rd, 32'h0);
    for (int k = 0; k < 4; k++) begin
      axi_read(5'(16 + 4*k), rd);
      check("post_reset_c", rd, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
